// File: rtl/mem_port_arbiter_if.sv
// Request/response handshakes for the fetch and data sides plus the shared memory bus.
// slave = arbiter view, master = requester/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_resp;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  logic                mem_valid;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_wen;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic                mem_ready;
  logic                mem_resp;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_err;

  logic                bus_valid;
  logic [ADDR_W-1:0]   bus_addr;
  logic                bus_wen;
  logic [DATA_W-1:0]   bus_wdata;
  logic [DATA_W/8-1:0] bus_wstrb;
  logic                bus_ready;
  logic                bus_resp_valid;
  logic [DATA_W-1:0]   bus_rdata;

  modport slave (
    input  if_valid, if_addr,
    output if_ready, if_resp, if_rdata, if_err,
    input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
    output mem_ready, mem_resp, mem_rdata, mem_err,
    output bus_valid, bus_addr, bus_wen, bus_wdata, bus_wstrb,
    input  bus_ready, bus_resp_valid, bus_rdata
  );

  modport master (
    output if_valid, if_addr,
    input  if_ready, if_resp, if_rdata, if_err,
    output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
    input  mem_ready, mem_resp, mem_rdata, mem_err,
    input  bus_valid, bus_addr, bus_wen, bus_wdata, bus_wstrb,
    output bus_ready, bus_resp_valid, bus_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one non-pipelined memory port between fetch and data; min 3 cycles accept->resp,
// bus stalls via bus_ready/bus_resp_valid, watchdog turns a stuck transaction into an error response.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave p
);
  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
  typedef enum logic {GNT_IF = 1'b0, GNT_MEM = 1'b1} gnt_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state, state_nxt;
  gnt_t                last_grant, grant, pick;
  logic [CNT_W-1:0]    wd;
  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_wen;
  logic [DATA_W-1:0]   lat_wdata;
  logic [DATA_W/8-1:0] lat_wstrb;
  logic                if_req, mem_req;
  logic                accept, complete, expire;

  // A side whose response is pulsing this cycle may not be granted again yet.
  assign if_req  = p.if_valid  & ~p.if_resp;
  assign mem_req = p.mem_valid & ~p.mem_resp;

  assign p.bus_valid = (state == ADDR);
  assign p.bus_addr  = lat_addr;
  assign p.bus_wen   = lat_wen;
  assign p.bus_wdata = lat_wdata;
  assign p.bus_wstrb = lat_wstrb;

  always_comb begin
    state_nxt   = state;
    pick        = GNT_IF;
    accept      = 1'b0;
    complete    = 1'b0;
    expire      = 1'b0;
    p.if_ready  = 1'b0;
    p.mem_ready = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || mem_req) begin
          accept      = 1'b1;
          pick        = (mem_req && (!if_req || last_grant == GNT_IF)) ? GNT_MEM : GNT_IF;
          p.mem_ready = (pick == GNT_MEM);
          p.if_ready  = (pick == GNT_IF);
          state_nxt   = ADDR;
        end
      end
      ADDR: begin
        if (wd == WD_LAST) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end else if (p.bus_ready) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (p.bus_resp_valid) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if (wd == WD_LAST) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_IF;
      grant      <= GNT_IF;
      wd         <= '0;
      lat_addr   <= '0;
      lat_wen    <= 1'b0;
      lat_wdata  <= '0;
      lat_wstrb  <= '0;
      p.if_resp   <= 1'b0;
      p.if_err    <= 1'b0;
      p.if_rdata  <= '0;
      p.mem_resp  <= 1'b0;
      p.mem_err   <= 1'b0;
      p.mem_rdata <= '0;
    end else begin
      state      <= state_nxt;
      p.if_resp  <= 1'b0;
      p.if_err   <= 1'b0;
      p.mem_resp <= 1'b0;
      p.mem_err  <= 1'b0;
      if (accept) begin
        grant      <= pick;
        last_grant <= pick;
        wd         <= '0;
        lat_addr   <= (pick == GNT_MEM) ? p.mem_addr : p.if_addr;
        lat_wen    <= (pick == GNT_MEM) & p.mem_wen;
        lat_wdata  <= (pick == GNT_MEM) ? p.mem_wdata : '0;
        lat_wstrb  <= (pick == GNT_MEM) ? p.mem_wstrb : '0;
      end else if (state != IDLE) begin
        wd <= wd + 1'b1;
      end
      if (complete || expire) begin
        if (grant == GNT_MEM) begin
          p.mem_resp  <= 1'b1;
          p.mem_err   <= expire;
          p.mem_rdata <= (complete && !lat_wen) ? p.bus_rdata : '0;
        end else begin
          p.if_resp  <= 1'b1;
          p.if_err   <= expire;
          p.if_rdata <= complete ? p.bus_rdata : '0;
        end
      end
    end
  end
endmodule
